// File: rtl/i2c_burst_reader.sv
// Single-master I2C burst reader: S, addr+W, reg, Sr, addr+R, N data bytes, P.
// SCL/SDA are open-drain; the *_oe outputs pull the line low when set.
module i2c_burst_reader #(
  parameter int         QTR        = 8,
  parameter logic [6:0] SLAVE_ADDR = 7'h19,
  parameter int         MAX_BYTES  = 6
) (
  input  logic                             clk12M,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [7:0]                       reg_addr,
  input  logic [$clog2(MAX_BYTES+1)-1:0]   byte_cnt,
  output logic                             busy,
  output logic                             done,
  output logic                             ack_err,
  output logic [8*MAX_BYTES-1:0]           rd_data,
  output logic                             scl_oe,
  output logic                             sda_oe,
  input  logic                             sda_i
);

  localparam int CW = $clog2(MAX_BYTES+1);
  localparam int QW = $clog2(QTR);
  localparam logic [QW-1:0] QLAST = QW'(QTR-1);
  localparam logic [CW-1:0] NMAX  = CW'(MAX_BYTES);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR_W, S_ACK1, S_REG, S_ACK2, S_RSTART,
    S_ADDR_R, S_ACK3, S_READ, S_MACK, S_ERR, S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [QW-1:0]          qcnt_q, qcnt_d;
  logic [2:0]             ph_q, ph_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             sh_q, sh_d;
  logic [7:0]             regad_q, regad_d;
  logic [CW-1:0]          rem_q, rem_d;
  logic [CW-1:0]          idx_q, idx_d;
  logic [8*MAX_BYTES-1:0] buf_q, buf_d;
  logic [8*MAX_BYTES-1:0] rd_data_q, rd_data_d;
  logic                   rx_q, rx_d;
  logic                   err_q, err_d;
  logic                   done_q, done_d;
  logic                   ack_err_q, ack_err_d;
  logic                   scl_oe_q, scl_oe_d;
  logic                   sda_oe_q, sda_oe_d;
  logic                   sync1_q, sync2_q;

  logic          tick, bit_end, samp;
  logic [CW-1:0] nbytes;

  assign tick    = (qcnt_q == QLAST);
  assign bit_end = tick && (ph_q == 3'd3);
  assign samp    = tick && (ph_q == 3'd2);

  always_comb begin
    nbytes = byte_cnt;
    if (byte_cnt == '0)       nbytes = CW'(1);
    else if (byte_cnt > NMAX) nbytes = NMAX;
  end

  always_comb begin
    state_d   = state_q;
    qcnt_d    = tick ? '0 : qcnt_q + 1'b1;
    ph_d      = tick ? ph_q + 3'd1 : ph_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    regad_d   = regad_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    rx_d      = rx_q;
    err_d     = err_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    rd_data_d = rd_data_q;
    scl_oe_d  = 1'b0;
    sda_oe_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        qcnt_d = '0;
        ph_d   = '0;
        // a start coinciding with the done pulse is dropped, not queued
        if (start && !done_q) begin
          state_d = S_START;
          regad_d = reg_addr;
          rem_d   = nbytes;
          idx_d   = '0;
          buf_d   = rd_data_q;
          err_d   = 1'b0;
        end
      end
      S_START: begin
        sda_oe_d = 1'b1;
        if (tick && ph_q == 3'd1) begin
          state_d = S_ADDR_W;
          ph_d    = '0;
          bit_d   = '0;
          sh_d    = {SLAVE_ADDR, 1'b0};
        end
      end
      S_ADDR_W, S_REG, S_ADDR_R: begin
        scl_oe_d = (ph_q < 3'd2);
        sda_oe_d = ~sh_q[7];
        if (bit_end) begin
          ph_d  = '0;
          bit_d = bit_q + 3'd1;
          sh_d  = {sh_q[6:0], 1'b0};
          if (bit_q == 3'd7) begin
            if (state_q == S_ADDR_W)  state_d = S_ACK1;
            else if (state_q == S_REG) state_d = S_ACK2;
            else                       state_d = S_ACK3;
          end
        end
      end
      S_ACK1, S_ACK2, S_ACK3: begin
        scl_oe_d = (ph_q < 3'd2);
        if (samp) rx_d = sync2_q;
        if (bit_end) begin
          ph_d  = '0;
          bit_d = '0;
          if (rx_q) begin
            state_d = S_ERR;
          end else if (state_q == S_ACK1) begin
            state_d = S_REG;
            sh_d    = regad_q;
          end else if (state_q == S_ACK2) begin
            state_d = S_RSTART;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_RSTART: begin
        scl_oe_d = (ph_q == 3'd0);
        sda_oe_d = (ph_q >= 3'd2);
        if (tick && ph_q == 3'd3) begin
          state_d = S_ADDR_R;
          ph_d    = '0;
          bit_d   = '0;
          sh_d    = {SLAVE_ADDR, 1'b1};
        end
      end
      S_READ: begin
        scl_oe_d = (ph_q < 3'd2);
        if (samp) sh_d = {sh_q[6:0], sync2_q};
        if (bit_end) begin
          ph_d  = '0;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_MACK;
            for (int k = 0; k < MAX_BYTES; k++)
              if (idx_q == CW'(k)) buf_d[8*k +: 8] = sh_q;
            idx_d = idx_q + 1'b1;
            rem_d = rem_q - 1'b1;
          end
        end
      end
      S_MACK: begin
        scl_oe_d = (ph_q < 3'd2);
        sda_oe_d = (rem_q != '0);
        if (bit_end) begin
          ph_d    = '0;
          state_d = (rem_q != '0) ? S_READ : S_STOP;
        end
      end
      S_ERR: begin
        err_d   = 1'b1;
        state_d = S_STOP;
        ph_d    = '0;
        qcnt_d  = '0;
      end
      S_STOP: begin
        scl_oe_d = (ph_q == 3'd0);
        sda_oe_d = (ph_q <= 3'd2);
        if (tick && ph_q == 3'd4) begin
          state_d   = S_IDLE;
          ph_d      = '0;
          done_d    = 1'b1;
          ack_err_d = err_q;
          if (!err_q) rd_data_d = buf_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk12M or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      qcnt_q    <= '0;
      ph_q      <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      regad_q   <= '0;
      rem_q     <= '0;
      idx_q     <= '0;
      buf_q     <= '0;
      rd_data_q <= '0;
      rx_q      <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      ph_q      <= ph_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      regad_q   <= regad_d;
      rem_q     <= rem_d;
      idx_q     <= idx_d;
      buf_q     <= buf_d;
      rd_data_q <= rd_data_d;
      rx_q      <= rx_d;
      err_q     <= err_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      scl_oe_q  <= scl_oe_d;
      sda_oe_q  <= sda_oe_d;
      sync1_q   <= sda_i;
      sync2_q   <= sync1_q;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign rd_data = rd_data_q;
  assign scl_oe  = scl_oe_q;
  assign sda_oe  = sda_oe_q;

endmodule

// File: tb/tb_i2c_burst_reader.sv
// Directed bench for i2c_burst_reader: bus-level slave model plus immediate-assert checks.
`timescale 1ns/1ps
module tb_i2c_burst_reader;

  logic        clk12M = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  reg_addr;
  logic [2:0]  byte_cnt;
  logic        busy, done, ack_err;
  logic [47:0] rd_data;
  logic        scl_oe, sda_oe;
  logic        slv_low = 1'b0;
  wire         scl_w = ~scl_oe;
  wire         sda_w = ~(sda_oe | slv_low);

  int vectors = 0;
  int errs    = 0;

  i2c_burst_reader #(.QTR(8), .SLAVE_ADDR(7'h19), .MAX_BYTES(6)) dut (
    .clk12M(clk12M), .rst_n(rst_n), .start(start), .reg_addr(reg_addr),
    .byte_cnt(byte_cnt), .busy(busy), .done(done), .ack_err(ack_err),
    .rd_data(rd_data), .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_i(sda_w)
  );

  always #5 clk12M = ~clk12M;

  // ---------------- slave model, sampled on the falling clock ----------------
  typedef enum {M_IDLE, M_ADDR, M_REG, M_RD} mode_t;
  mode_t      md = M_IDLE;
  logic [6:0] model_addr = 7'h19;
  logic       nack_reg   = 1'b0;
  logic       scl_p = 1'b1, sda_p = 1'b1;
  logic [7:0] sh = 8'h00, ptr = 8'h00, rb = 8'h00;
  logic       ack = 1'b0, mack = 1'b0;
  int bitn = 0, rbi = 0, cyc = 0, last_rise = -1;
  int n_rise = 0, n_start = 0, n_stop = 0, n_p32 = 0, n_po = 0;
  int n_mack = 0, n_mnack = 0, n_done = 0;
  logic [7:0] wq[$];

  function automatic logic [7:0] regval(input logic [7:0] p);
    case (p)
      8'h28: return 8'h11;
      8'h29: return 8'h22;
      8'h2A: return 8'h33;
      8'h2B: return 8'h44;
      8'h2C: return 8'h55;
      8'h2D: return 8'h66;
      default: return 8'hEE;
    endcase
  endfunction

  always @(negedge clk12M) begin
    cyc++;
    if (!rst_n) begin
      md = M_IDLE; slv_low = 1'b0; last_rise = -1;
    end else if (scl_w && scl_p && sda_p && !sda_w) begin
      n_start++; md = M_ADDR; bitn = 0; slv_low = 1'b0;
    end else if (scl_w && scl_p && !sda_p && sda_w) begin
      n_stop++; md = M_IDLE; slv_low = 1'b0; last_rise = -1;
    end else if (scl_w && !scl_p) begin
      n_rise++;
      if (last_rise >= 0) begin
        if (cyc - last_rise == 32) n_p32++; else n_po++;
      end
      last_rise = cyc;
      if (md != M_IDLE) begin
        if (bitn < 8 && md != M_RD) sh = {sh[6:0], sda_w};
        if (bitn == 8 && md == M_RD) begin
          mack = !sda_w;
          if (mack) n_mack++; else n_mnack++;
        end
        bitn++;
      end
    end else if (!scl_w && scl_p && md != M_IDLE) begin
      if (bitn == 8) begin
        if (md == M_RD) slv_low = 1'b0;
        else begin
          wq.push_back(sh);
          ack = (md == M_ADDR) ? (sh[7:1] == model_addr) : !nack_reg;
          slv_low = ack;
        end
      end else if (bitn == 9) begin
        bitn = 0; slv_low = 1'b0;
        case (md)
          M_ADDR: begin
            if (!ack) md = M_IDLE;
            else if (sh[0]) begin
              md = M_RD; rb = regval(ptr); slv_low = !rb[7]; rbi = 1;
            end else md = M_REG;
          end
          M_REG: begin ptr = sh & 8'h7F; md = M_IDLE; end
          M_RD: begin
            if (mack) begin
              ptr = ptr + 8'd1; rb = regval(ptr); slv_low = !rb[7]; rbi++;
            end else md = M_IDLE;
          end
          default: md = M_IDLE;
        endcase
      end else if (md == M_RD && bitn >= 1) begin
        slv_low = !rb[7-bitn];
      end
    end
    if (done) n_done++;
    scl_p = scl_w;
    sda_p = sda_w;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int s_rise, s_start, s_stop, s_p32, s_po, s_mack, s_mnack, s_done, s_wq;
  task automatic snap();
    s_rise = n_rise; s_start = n_start; s_stop = n_stop; s_p32 = n_p32; s_po = n_po;
    s_mack = n_mack; s_mnack = n_mnack; s_done = n_done; s_wq = wq.size();
  endtask

  // Overhead beyond the 4*QTR bit slots: start 2 + repeated start 4 + stop 5 quarters.
  function automatic int exp_lat(input int n);
    return (27 + 9*n)*4*8 + 11*8;
  endfunction

  task automatic run(input logic [7:0] ra, input logic [2:0] bc, input bit poke, output int lat);
    snap();
    @(negedge clk12M); reg_addr = ra; byte_cnt = bc; start = 1'b1;
    @(negedge clk12M); start = 1'b0; lat = 0;
    while (done !== 1'b1 && lat < 6000) begin
      @(negedge clk12M); lat++;
      if (poke && lat == 200) begin start = 1'b1; reg_addr = 8'h00; end
      if (poke && lat == 201) start = 1'b0;
    end
    chk("done_seen", done, 1'b1);
    chk("busy_low_on_done", busy, 1'b0);
    if (poke) start = 1'b1;
    @(negedge clk12M); start = 1'b0;
    chk("done_one_cycle", done, 1'b0);
    chk("idle_after_done", busy, 1'b0);
  endtask

  int lat;
  int wait_n;

  initial begin
    rst_n = 1'b0; start = 1'b0; reg_addr = 8'h00; byte_cnt = 3'd0;
    repeat (3) @(negedge clk12M);
    chk("rst_scl_oe", scl_oe, 1'b0);
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ack_err", ack_err, 1'b0);
    chk("rst_rd_data", rd_data, 48'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk12M);

    // full 6-byte burst, with start pulses while busy and on the done cycle
    run(8'hA8, 3'd6, 1'b1, lat);
    chk("burst_rd_data", rd_data, 48'h665544332211);
    chk("burst_ack_err", ack_err, 1'b0);
    vectors++;
    assert (lat >= exp_lat(6) - 2 && lat <= exp_lat(6) + 2) else begin
      errs++; $error("FAIL burst_latency: observed %0d expected %0d", lat, exp_lat(6));
    end
    chk("wire_byte0", wq[s_wq], 8'h32);
    chk("wire_byte1", wq[s_wq+1], 8'hA8);
    chk("wire_byte2", wq[s_wq+2], 8'h33);
    chk("burst_starts", n_start - s_start, 2);
    chk("burst_stops", n_stop - s_stop, 1);
    chk("burst_scl_rises", n_rise - s_rise, 83);
    chk("burst_scl_32_periods", n_p32 - s_p32, 79);
    chk("burst_scl_other_gaps", n_po - s_po, 3);
    chk("burst_master_acks", n_mack - s_mack, 5);
    chk("burst_master_nacks", n_mnack - s_mnack, 1);
    repeat (60) @(negedge clk12M);
    chk("no_queued_start", busy, 1'b0);
    chk("burst_done_pulses", n_done - s_done, 1);

    // slave at another address: no ACK to 0x32
    model_addr = 7'h18;
    run(8'hA8, 3'd6, 1'b0, lat);
    chk("addr_nack_err", ack_err, 1'b1);
    chk("addr_nack_rd_data", rd_data, 48'h665544332211);
    chk("addr_nack_rises", n_rise - s_rise, 10);
    chk("addr_nack_starts", n_start - s_start, 1);
    chk("addr_nack_stops", n_stop - s_stop, 1);
    chk("addr_nack_bytes", wq.size() - s_wq, 1);
    model_addr = 7'h19;

    // slave NACKs the register byte: no repeated start
    nack_reg = 1'b1;
    run(8'hA8, 3'd6, 1'b0, lat);
    chk("reg_nack_err", ack_err, 1'b1);
    chk("reg_nack_rd_data", rd_data, 48'h665544332211);
    chk("reg_nack_rises", n_rise - s_rise, 19);
    chk("reg_nack_starts", n_start - s_start, 1);
    chk("reg_nack_bytes", wq.size() - s_wq, 2);
    nack_reg = 1'b0;

    // single-byte reads: explicit 1, then 0 treated as 1
    run(8'hAD, 3'd1, 1'b0, lat);
    chk("one_byte_rd_data", rd_data, 48'h665544332266);
    chk("one_byte_ack_err", ack_err, 1'b0);
    chk("one_byte_acks", n_mack - s_mack, 0);
    chk("one_byte_nacks", n_mnack - s_mnack, 1);
    vectors++;
    assert (lat >= exp_lat(1) - 2 && lat <= exp_lat(1) + 2) else begin
      errs++; $error("FAIL one_byte_latency: observed %0d expected %0d", lat, exp_lat(1));
    end
    run(8'hA9, 3'd0, 1'b0, lat);
    chk("zero_cnt_rd_data", rd_data, 48'h665544332222);
    chk("zero_cnt_rises", n_rise - s_rise, 38);
    chk("zero_cnt_nacks", n_mnack - s_mnack, 1);

    // reset in the middle of the third data byte while SCL is held low
    snap();
    @(negedge clk12M); reg_addr = 8'hA8; byte_cnt = 3'd6; start = 1'b1;
    @(negedge clk12M); start = 1'b0;
    wait_n = 0;
    while (!(md == M_RD && rbi == 3 && bitn == 4 && !scl_w) && wait_n < 6000) begin
      @(posedge clk12M); wait_n++;
    end
    chk("reach_third_byte", (wait_n < 6000), 1'b1);
    @(negedge clk12M); rst_n = 1'b0;
    #1;
    chk("midrst_scl_oe", scl_oe, 1'b0);
    chk("midrst_sda_oe", sda_oe, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    repeat (10) @(negedge clk12M);
    rst_n = 1'b1;
    repeat (40) @(negedge clk12M);
    chk("midrst_no_done", n_done - s_done, 0);
    chk("midrst_rd_data", rd_data, 48'h0);
    chk("midrst_idle", busy, 1'b0);

    // recovery; byte count above the maximum is clamped
    run(8'hA8, 3'd7, 1'b0, lat);
    chk("clamp_rd_data", rd_data, 48'h665544332211);
    chk("clamp_acks", n_mack - s_mack, 5);
    chk("clamp_nacks", n_mnack - s_mnack, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
